// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must be able to hold the value W itself.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor; ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int W = 3
);
  import serial_sub_pkg::*;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (output start, a, b, input busy, done, d, bo, ovf);
  modport slave  (input start, a, b, output busy, done, d, bo, ovf);
`else
  modport master (output start, a, b, input busy, done, d, bo);
  modport slave  (input start, a, b, output busy, done, d, bo);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Borrow is generated when x<y, or propagated when x==y.
  always_comb begin
    diff = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor d = a - b, LSB first, with start/done handshake.
// Optional signed overflow flag is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = 3
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t         state_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   res_r;
  logic [CW-1:0]  cnt_r;
  logic           br_r;
  logic           busy_r;
  logic           done_r;
  logic [W-1:0]   d_r;
  logic           bo_r;
  logic           diff_s;
  logic           bout_s;
  logic [W-1:0]   res_next_s;
`ifdef SERIAL_SUB_OVF_EN
  logic           sa_r;
  logic           sb_r;
  logic           ovf_r;
`endif

  full_subtractor u_fs (
    .x    (a_r[0]),
    .y    (b_r[0]),
    .bin  (br_r),
    .diff (diff_s),
    .bout (bout_s)
  );

  // Result bits enter from the MSB side so the LSB lands at bit 0 after W shifts.
  always_comb begin
    res_next_s = {diff_s, res_r[W-1:1]};
  end

  // Control FSM plus datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      res_r   <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      br_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      d_r     <= {W{1'b0}};
      bo_r    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= RUN;
            a_r     <= bus.a;
            b_r     <= bus.b;
            res_r   <= {W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            br_r    <= 1'b0;
            busy_r  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            sa_r    <= bus.a[W-1];
            sb_r    <= bus.b[W-1];
`endif
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          a_r   <= {1'b0, a_r[W-1:1]};
          b_r   <= {1'b0, b_r[W-1:1]};
          res_r <= res_next_s;
          br_r  <= bout_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            d_r     <= res_next_s;
            bo_r    <= bout_s;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r   <= (sa_r != sb_r) && (diff_s != sa_r);
`endif
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.d    = d_r;
  assign bus.bo   = bo_r;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=3), optional SERIAL_SUB_OVF_EN coverage.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 3;
  localparam int MOD = 1 << W;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  serial_subtractor_if #(.W(W)) bus ();

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic int ref_d(input int av, input int bv);
    return ((av - bv) % MOD + MOD) % MOD;
  endfunction

  function automatic int ref_bo(input int av, input int bv);
    return (av < bv) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(input int av, input int bv);
    int sa, sb, t;
    sa = (av >= MOD / 2) ? av - MOD : av;
    sb = (bv >= MOD / 2) ? bv - MOD : bv;
    t  = sa - sb;
    return (t < -(MOD / 2) || t > (MOD / 2 - 1)) ? 1 : 0;
  endfunction

  task automatic run_op(input int av, input int bv);
    bit seen;
    int busy_n;
    seen   = 1'b0;
    busy_n = 0;
    bus.start = 1'b1;
    bus.a = W'(av);
    bus.b = W'(bv);
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      chk("no_overlap", 32'(bus.busy & bus.done), 32'd0);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        chk("done_latency", k, W + 1);
        chk("busy_cycles", busy_n, W);
        chk("d", 32'(bus.d), ref_d(av, bv));
        chk("bo", 32'(bus.bo), ref_bo(av, bv));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), ref_ovf(av, bv));
`endif
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_bo", 32'(bus.bo), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed operands.
    run_op(5, 3);
    run_op(3, 5);
    run_op(0, 7);
    run_op(7, 7);

    // Randomized operands, back-to-back through DONE.
    for (int i = 0; i < 24; i++) run_op($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
    repeat (3) @(negedge clk);

    // Start held high: one result every W+1 cycles.
    bus.start = 1'b1;
    bus.a = W'(5);
    bus.b = W'(3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("held_done", 32'(bus.done), (k % (W + 1) == 0) ? 32'd1 : 32'd0);
      chk("held_busy", 32'(bus.busy), (k % (W + 1) != 0) ? 32'd1 : 32'd0);
      if (bus.done) chk("held_d", 32'(bus.d), 32'd2);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_idle", 32'(bus.busy), 32'd0);

    // Start during RUN is ignored.
    bus.start = 1'b1;
    bus.a = W'(6);
    bus.b = W'(2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin
        bus.start = 1'b1;
        bus.a = W'(1);
        bus.b = W'(1);
      end
      if (k == 3) bus.start = 1'b0;
      chk("ign_done", 32'(bus.done), (k == W + 1) ? 32'd1 : 32'd0);
      if (k == W + 1) chk("ign_d", 32'(bus.d), 32'd4);
      if (k > W + 1) chk("ign_no_restart", 32'(bus.busy), 32'd0);
    end

    // Reset in the second RUN cycle discards the operation.
    run_op(1, 2);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(6);
    bus.b = W'(2);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_d", 32'(bus.d), 32'd0);
    chk("mid_rst_bo", 32'(bus.bo), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(bus.done), 32'd0);
    end
    run_op(4, 1);

`ifdef SERIAL_SUB_OVF_EN
    run_op(3, 4);
    run_op(2, 1);
    run_op(4, 1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
